// File: rtl/multi_edge_debounce_if.sv
// Signal bundle between raw board inputs / user logic and multi_edge_debounce.
// Inputs are sampled on the rising clock edge; outputs change only on that edge.
interface multi_edge_debounce_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       IN;
  logic [CHANNELS-1:0]       CLR_STICKY;
  logic [CHANNELS-1:0]       CLR_CNT;
  logic [CHANNELS-1:0]       STABLE;
  logic [CHANNELS-1:0]       EDGE;
  logic [CHANNELS-1:0]       STICKY;
  logic [CHANNELS*CNT_W-1:0] EVT_CNT;

  // master drives raw levels and clears; slave (the debouncer) drives status
  modport master (
    output IN, CLR_STICKY, CLR_CNT,
    input  STABLE, EDGE, STICKY, EVT_CNT
  );

  modport slave (
    input  IN, CLR_STICKY, CLR_CNT,
    output STABLE, EDGE, STICKY, EVT_CNT
  );
endinterface

// File: rtl/multi_edge_debounce.sv
// Per-channel synchroniser, debouncer and edge detector with sticky flags
// and saturating event counters, running on the system clock.
module multi_edge_debounce #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 250000,
  parameter int DB_W        = 18,
  parameter int EDGE_MODE   = 0,
  parameter int CNT_W       = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  multi_edge_debounce_if.slave bus
);

  if (DB_COUNT < 1 || SYNC_STAGES < 2 || EDGE_MODE < 0 || EDGE_MODE > 2 ||
      (64'd1 << DB_W) <= 64'(DB_COUNT)) begin : g_bad_params
    $error("multi_edge_debounce: illegal parameter combination");
  end

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reset asserts asynchronously, releases on the clock
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  logic [SYNC_STAGES-1:0]    sync_q    [CHANNELS];
  logic [DB_W-1:0]           db_cnt_q  [CHANNELS];
  logic [CNT_W-1:0]          evt_cnt_q [CHANNELS];
  logic [CHANNELS-1:0]       stable_q;
  logic [CHANNELS-1:0]       edge_q;
  logic [CHANNELS-1:0]       sticky_q;
  logic [CHANNELS-1:0]       s_lvl;
  logic [CHANNELS-1:0]       toggle;
  logic [CHANNELS-1:0]       evt;
  logic [CHANNELS*CNT_W-1:0] evt_cnt_flat;

  // toggle: the new level has persisted long enough and STABLE flips this edge
  always_comb begin
    s_lvl  = '0;
    toggle = '0;
    evt    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s_lvl[c]  = sync_q[c][SYNC_STAGES-1];
      toggle[c] = (s_lvl[c] != stable_q[c]) && (db_cnt_q[c] == DB_LAST);
      case (EDGE_MODE)
        0:       evt[c] = toggle[c] & ~stable_q[c];
        1:       evt[c] = toggle[c] &  stable_q[c];
        default: evt[c] = toggle[c];
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c]    <= '0;
        db_cnt_q[c]  <= '0;
        evt_cnt_q[c] <= '0;
      end
      stable_q <= '0;
      edge_q   <= '0;
      sticky_q <= '0;
    end else begin
      edge_q   <= evt;
      stable_q <= stable_q ^ toggle;
      // a new event wins over a coincident clear
      sticky_q <= evt | (sticky_q & ~bus.CLR_STICKY);
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], bus.IN[c]};
        if ((s_lvl[c] == stable_q[c]) || toggle[c]) db_cnt_q[c] <= '0;
        else                                        db_cnt_q[c] <= db_cnt_q[c] + DB_W'(1);
        if (bus.CLR_CNT[c])
          evt_cnt_q[c] <= evt[c] ? CNT_W'(1) : '0;
        else if (evt[c] && (evt_cnt_q[c] != CNT_MAX))
          evt_cnt_q[c] <= evt_cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    evt_cnt_flat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      evt_cnt_flat[c*CNT_W +: CNT_W] = evt_cnt_q[c];
    end
  end

  assign bus.STABLE  = stable_q;
  assign bus.EDGE    = edge_q;
  assign bus.STICKY  = sticky_q;
  assign bus.EVT_CNT = evt_cnt_flat;

endmodule

// File: tb/tb_multi_edge_debounce.sv
// Directed bench: three debouncers (rising, falling, both-edge modes) share
// one stimulus stream; DB_COUNT=4 so a level needs 6 clock edges to register.
module tb_multi_edge_debounce;
  localparam int CH = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] in_drv = '0;
  logic [CH-1:0] clr_sticky = '0;
  logic [CH-1:0] clr_cnt = '0;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  multi_edge_debounce_if #(.CHANNELS(CH), .CNT_W(CW)) if0 ();
  multi_edge_debounce_if #(.CHANNELS(CH), .CNT_W(CW)) if1 ();
  multi_edge_debounce_if #(.CHANNELS(CH), .CNT_W(CW)) if2 ();

  assign if0.IN = in_drv;  assign if0.CLR_STICKY = clr_sticky;  assign if0.CLR_CNT = clr_cnt;
  assign if1.IN = in_drv;  assign if1.CLR_STICKY = clr_sticky;  assign if1.CLR_CNT = clr_cnt;
  assign if2.IN = in_drv;  assign if2.CLR_STICKY = clr_sticky;  assign if2.CLR_CNT = clr_cnt;

  multi_edge_debounce #(.CHANNELS(CH), .SYNC_STAGES(2), .DB_COUNT(4), .DB_W(3),
                        .EDGE_MODE(0), .CNT_W(CW))
    u0 (.CLK(clk), .RST_N(rst_n), .bus(if0));
  multi_edge_debounce #(.CHANNELS(CH), .SYNC_STAGES(2), .DB_COUNT(4), .DB_W(3),
                        .EDGE_MODE(1), .CNT_W(CW))
    u1 (.CLK(clk), .RST_N(rst_n), .bus(if1));
  multi_edge_debounce #(.CHANNELS(CH), .SYNC_STAGES(2), .DB_COUNT(4), .DB_W(3),
                        .EDGE_MODE(2), .CNT_W(CW))
    u2 (.CLK(clk), .RST_N(rst_n), .bus(if2));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick(3);
    check("rst_stable",  32'(if0.STABLE),  32'h0);
    check("rst_edge",    32'(if0.EDGE),    32'h0);
    check("rst_sticky",  32'(if0.STICKY),  32'h0);
    check("rst_evt_cnt", 32'(if0.EVT_CNT), 32'h0);
    rst_n = 1'b1;
    tick(4);

    // 1: clean rise on ch0
    in_drv[0] = 1'b1;
    tick(5);
    check("t1_stable_early", 32'(if0.STABLE), 32'h0);
    check("t1_edge_early",   32'(if0.EDGE),   32'h0);
    tick(1);
    check("t1_stable",  32'(if0.STABLE),  32'h1);
    check("t1_edge",    32'(if0.EDGE),    32'h1);
    check("t1_sticky",  32'(if0.STICKY),  32'h1);
    check("t1_evt_cnt", 32'(if0.EVT_CNT), 32'h001);
    tick(1);
    check("t1_edge_drop", 32'(if0.EDGE), 32'h0);

    // 2: 3-cycle glitch rejected, then bounce before a real press
    in_drv[1] = 1'b1;  tick(3);
    in_drv[1] = 1'b0;  tick(8);
    check("t2_glitch_stable", 32'(if0.STABLE),  32'h1);
    check("t2_glitch_sticky", 32'(if0.STICKY),  32'h1);
    check("t2_glitch_cnt",    32'(if0.EVT_CNT), 32'h001);
    in_drv[1] = 1'b1;  tick(3);
    in_drv[1] = 1'b0;  tick(1);
    in_drv[1] = 1'b1;  tick(5);
    check("t2_bounce_early", 32'(if0.STABLE), 32'h1);
    tick(1);
    check("t2_bounce_stable", 32'(if0.STABLE),  32'h3);
    check("t2_bounce_edge",   32'(if0.EDGE),    32'h2);
    check("t2_bounce_cnt",    32'(if0.EVT_CNT), 32'h009);
    tick(1);
    check("t2_edge_drop", 32'(if0.EDGE), 32'h0);

    // 3: ch2 rise then fall across the three edge modes
    in_drv[2] = 1'b1;  tick(6);
    check("t3_rise_m0", 32'(if0.EDGE), 32'h4);
    check("t3_rise_m1", 32'(if1.EDGE), 32'h0);
    check("t3_rise_m2", 32'(if2.EDGE), 32'h4);
    in_drv[2] = 1'b0;  tick(5);
    check("t3_fall_early", 32'(if0.STABLE), 32'h7);
    tick(1);
    check("t3_fall_stable_m0", 32'(if0.STABLE), 32'h3);
    check("t3_fall_m0",        32'(if0.EDGE),   32'h0);
    check("t3_fall_m1",        32'(if1.EDGE),   32'h4);
    check("t3_fall_m2",        32'(if2.EDGE),   32'h4);
    check("t3_cnt_m0",         32'(if0.EVT_CNT), 32'h049);
    check("t3_sticky_m1",      32'(if1.STICKY),  32'h4);
    check("t3_cnt_ch2_m2",     32'(if2.EVT_CNT[8:6]), 32'h2);

    // 4: counter saturation, clear coincident with an event
    for (int k = 1; k <= 9; k++) begin
      in_drv[3] = 1'b1;  tick(6);
      check("t4_edge",    32'(if0.EDGE[3]),       32'h1);
      check("t4_cnt_sat", 32'(if0.EVT_CNT[11:9]), (k > 7) ? 32'h7 : 32'(k));
      in_drv[3] = 1'b0;  tick(6);
    end
    in_drv[3] = 1'b1;  tick(5);
    clr_cnt[3] = 1'b1;  clr_sticky[3] = 1'b1;
    tick(1);
    clr_cnt[3] = 1'b0;  clr_sticky[3] = 1'b0;
    check("t4_clr_edge",   32'(if0.EDGE[3]),       32'h1);
    check("t4_clr_cnt",    32'(if0.EVT_CNT[11:9]), 32'h1);
    check("t4_clr_sticky", 32'(if0.STICKY),        32'hf);
    in_drv[3] = 1'b0;  tick(6);
    clr_sticky[3] = 1'b1;  clr_cnt[3] = 1'b1;
    tick(1);
    clr_sticky[3] = 1'b0;  clr_cnt[3] = 1'b0;
    check("t4_sticky_alone", 32'(if0.STICKY),  32'h7);
    check("t4_cnt_alone",    32'(if0.EVT_CNT), 32'h049);

    // 5: reset in the middle of a debounce on ch0
    in_drv[0] = 1'b0;  tick(6);
    check("t5_pre_stable", 32'(if0.STABLE), 32'h2);
    in_drv[0] = 1'b1;  tick(4);
    rst_n = 1'b0;
    #1;
    check("t5_async_stable", 32'(if0.STABLE),  32'h0);
    check("t5_async_edge",   32'(if0.EDGE),    32'h0);
    check("t5_async_sticky", 32'(if0.STICKY),  32'h0);
    check("t5_async_cnt",    32'(if0.EVT_CNT), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(7);
    check("t5_edge_early",   32'(if0.EDGE),   32'h0);
    check("t5_stable_early", 32'(if0.STABLE), 32'h0);
    tick(1);
    check("t5_edge",    32'(if0.EDGE),    32'h3);
    check("t5_sticky",  32'(if0.STICKY),  32'h3);
    check("t5_evt_cnt", 32'(if0.EVT_CNT), 32'h009);
    tick(1);
    check("t5_edge_drop", 32'(if0.EDGE), 32'h0);

    // 6: all channels rise together
    in_drv = '0;  tick(6);
    check("t6_all_low", 32'(if0.STABLE), 32'h0);
    clr_cnt = '1;  tick(1);
    clr_cnt = '0;
    in_drv = '1;  tick(5);
    check("t6_edge_early", 32'(if0.EDGE), 32'h0);
    tick(1);
    check("t6_edge_m0", 32'(if0.EDGE),    32'hf);
    check("t6_edge_m1", 32'(if1.EDGE),    32'h0);
    check("t6_edge_m2", 32'(if2.EDGE),    32'hf);
    check("t6_cnt",     32'(if0.EVT_CNT), 32'h249);
    check("t6_sticky",  32'(if0.STICKY),  32'hf);
    tick(1);
    check("t6_edge_drop", 32'(if0.EDGE), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
